// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-size modes, default round counts, controller states and rcon lookup.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'b00,
        MODE_192  = 2'b01,
        MODE_256  = 2'b10,
        MODE_RSVD = 2'b11
    } aes_mode_e;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } round_state_e;

    // Only rounds 1..10 carry a nonzero constant; everything else maps to zero.
    function automatic logic [7:0] rcon_f(input int unsigned r);
        case (r)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_rcon_lut.sv
// aes_rcon_lut: combinational round index to key-schedule round constant map.
module aes_rcon_lut
    import aes_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] round,
    output logic [7:0]       rcon
);

    assign rcon = rcon_f(32'(round));

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: start/done handshaked AES round sequencer for 128/192/256-bit keys
// with stall, abort, per-round flags and round constant.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] round_o,
    output logic             first_o,
    output logic             last_o,
    output logic [7:0]       rcon_o,
    output logic             done_o
);

    round_state_e     state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic [CNT_W-1:0] mode_nr;
    logic [7:0]       lut_rcon;

    // Reserved mode falls through to the 128-bit round count.
    assign mode_nr = (mode_i == MODE_192) ? CNT_W'(NR_192) :
                     (mode_i == MODE_256) ? CNT_W'(NR_256) : CNT_W'(NR_128);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            nr_q    <= CNT_W'(NR_128);
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_RUN;
                round_d = '0;
                nr_d    = mode_nr;
            end
            ST_RUN: if (abort_i) begin
                state_d = ST_IDLE;
                round_d = '0;
            end else if (en_i) begin
                state_d = (round_q == nr_q) ? ST_DONE : ST_RUN;
                round_d = (round_q == nr_q) ? '0 : round_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    aes_rcon_lut #(.CNT_W(CNT_W)) u_rcon_lut (
        .round (round_q),
        .rcon  (lut_rcon)
    );

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign round_o = round_q;
    assign first_o = busy_o && (round_q == '0);
    assign last_o  = busy_o && (round_q == nr_q);
    assign rcon_o  = busy_o ? lut_rcon : 8'h00;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed self-checking bench for the AES round sequencer.
module tb_aes_round_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic       en_i = 1'b1;
    logic       abort_i = 1'b0;
    logic       ready_o, busy_o, first_o, last_o, done_o;
    logic [3:0] round_o;
    logic [7:0] rcon_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] rc_tab [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    aes_round_ctrl dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .en_i    (en_i),
        .abort_i (abort_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .round_o (round_o),
        .first_o (first_o),
        .last_o  (last_o),
        .rcon_o  (rcon_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] st();
        return 32'({ready_o, busy_o, done_o, first_o, last_o});
    endfunction

    // Starts an operation, walks every round, optionally stalls, then checks done and idle.
    task automatic run_op(input logic [1:0] m, input int nr, input int st_at, input int st_n,
                          input bit hold);
        start_i = 1'b1;
        mode_i  = m;
        en_i    = 1'b1;
        step();
        if (!hold) start_i = 1'b0;
        mode_i = m ^ 2'b01;
        for (int k = 0; k <= nr; k++) begin
            chk("run_st", st(), 32'({3'b010, k == 0, k == nr}));
            chk("run_round", 32'(round_o), 32'(k));
            chk("run_rcon", 32'(rcon_o), 32'(rc_tab[k]));
            if (k == st_at) begin
                en_i = 1'b0;
                repeat (st_n) begin
                    step();
                    chk("stall_round", 32'(round_o), 32'(k));
                    chk("stall_st", st(), 32'({3'b010, k == 0, k == nr}));
                end
                en_i = 1'b1;
            end
            step();
        end
        chk("done_st", st(), 32'(5'b00100));
        chk("done_round", 32'(round_o), 32'd0);
        chk("done_rcon", 32'(rcon_o), 32'd0);
        step();
        chk("idle_st", st(), 32'(5'b10000));
        chk("idle_round", 32'(round_o), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_st", st(), 32'(5'b10000));
        chk("rst_round", 32'(round_o), 32'd0);
        chk("rst_rcon", 32'(rcon_o), 32'd0);
        #10 reset_i = 1'b0;
        step();
        chk("post_rst_st", st(), 32'(5'b10000));

        run_op(2'b00, 10, -1, 0, 1'b0);
        run_op(2'b01, 12, -1, 0, 1'b0);
        run_op(2'b10, 14, -1, 0, 1'b0);
        run_op(2'b11, 10, -1, 0, 1'b0);
        run_op(2'b00, 10, 5, 3, 1'b0);

        // Abort at round 7 with en_i also high.
        start_i = 1'b1;
        mode_i  = 2'b00;
        step();
        start_i = 1'b0;
        repeat (7) step();
        chk("pre_abort_round", 32'(round_o), 32'd7);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_st", st(), 32'(5'b10000));
        chk("abort_round", 32'(round_o), 32'd0);
        step();
        chk("abort_nodone", st(), 32'(5'b10000));
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("idle_abort_st", st(), 32'(5'b10000));

        // start_i held high: second op accepted only on the IDLE cycle after done.
        run_op(2'b00, 10, -1, 0, 1'b1);
        run_op(2'b10, 14, -1, 0, 1'b0);

        // Asynchronous reset mid-run at round 9.
        start_i = 1'b1;
        mode_i  = 2'b01;
        step();
        start_i = 1'b0;
        repeat (9) step();
        chk("pre_rst_round", 32'(round_o), 32'd9);
        #2 reset_i = 1'b1;
        #1;
        chk("async_rst_st", st(), 32'(5'b10000));
        chk("async_rst_round", 32'(round_o), 32'd0);
        #1 reset_i = 1'b0;
        step();
        chk("rst_rel_st", st(), 32'(5'b10000));
        run_op(2'b00, 10, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised AES round sequencer for the AES accelerator. It replaces the fixed 10-round counter with a start/done-handshaked controller supporting AES-128/192/256 round counts, stall, and abort. It also emits per-round flags and the key-schedule round constant. It sits between the accelerator's command interface and the round datapath/key-expansion logic.

## Interface
- CNT_W, 4: width of round_o; must satisfy 2^CNT_W > max(NR_128, NR_192, NR_256)
- NR_128, 10: final round index for mode 2'b00
- NR_192, 12: final round index for mode 2'b01
- NR_256, 14: final round index for mode 2'b10

- clk_i  in  1  clock, rising edge
- reset_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request a new operation; accepted only while ready_o=1
- mode_i  in  2  key size: 00=128, 01=192, 10=256, 11 reserved (treated as 128); sampled only on accepted start
- en_i  in  1  advance one round this cycle; low = stall/hold
- abort_i  in  1  cancel the running operation
- ready_o  out  1  controller idle, start_i will be accepted
- busy_o  out  1  operation in progress (RUN state)
- round_o  out  CNT_W  current round index, 0..Nr
- first_o  out  1  RUN and round_o==0 (initial AddRoundKey)
- last_o  out  1  RUN and round_o==Nr (final round, no MixColumns)
- rcon_o  out  8  round constant for current round_o
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready_o=1. start_i=1 latches Nr from mode_i, clears round_o to 0 and goes to RUN.
- RUN: with en_i=1 and round_o<Nr, round_o increments. With en_i=1 and round_o==Nr, the FSM goes to DONE and round_o is cleared to 0. With en_i=0, all state holds.
- DONE: done_o=1 for exactly one cycle, then unconditional return to IDLE. A start_i in DONE is ignored.
- abort_i in RUN: return to IDLE next cycle, round_o=0, no done_o. abort_i has priority over en_i. abort_i in IDLE or DONE has no effect.
- start_i outside IDLE is ignored. mode_i changes after acceptance do not affect the latched Nr.
- rcon_o table indexed by round_o:
  - rounds 1..10 → 01,02,04,08,10,20,40,80,1B,36
  - round 0 and rounds >10 → 00
  - outside RUN → 00
- ready_o, busy_o and done_o are mutually exclusive and exactly one is high at all times after reset.
- Reset, effective immediately on assertion: IDLE, ready_o=1, all other outputs 0, latched Nr=NR_128.

## Timing
- All outputs are registered-state decodes; there are no combinational paths from inputs to outputs.
- Start accepted at edge t: at t+1, busy_o=1, round_o=0, first_o=1.
- With en_i held high, round k is presented at t+1+k. last_o is high at t+1+Nr. done_o is high at t+2+Nr. ready_o is high at t+3+Nr.
- Each en_i=0 cycle in RUN adds exactly one cycle of latency.
- Back-to-back operation: start_i may be issued in the first IDLE cycle after DONE, giving a minimum start-to-start spacing of Nr+3 cycles.
- Reset asserted mid-RUN: outputs take their reset values asynchronously. The first edge after deassertion behaves as IDLE.

## Structure
- Shared package aes_pkg holds:
  - aes_mode_e, the 2-bit key-size enum
  - the NR_* default constants
  - the FSM state enum
  - the rcon lookup function
- One sub-module: aes_rcon_lut, a combinational round_o→rcon_o map, reused by the key-expansion block.
- Round register, FSM and latched Nr live in aes_round_ctrl.

## Test plan
- Reset then start, mode=00, en_i=1 → round_o 0..10 on consecutive cycles, first_o only at 0, last_o only at 10, rcon_o 00,01,…,36, done_o pulse 12 cycles after start edge.
- mode=01 and mode=10, en_i=1 → last_o at round 12 and 14 respectively, done_o at 14 and 16 cycles after start. mode=11 → identical to mode=00.
- Stall: mode=00, en_i low for 3 cycles at round 5 → round_o holds 5, done_o delayed by exactly 3 cycles.
- Abort at round 7 → IDLE next cycle, round_o=0, ready_o=1, no done_o. Simultaneous en_i=1 and abort_i → abort wins.
- start_i held high throughout → a second operation is accepted only on the first IDLE cycle after done_o. A mode_i change mid-run is ignored.
- reset_i pulsed asynchronously mid-RUN at round 9 → immediate ready_o=1, round_o=0, busy_o=0. A clean operation follows after release.
